// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the UART RX frame controller and its environment
// (serial line, frame configuration, sampler handshake, received-data outputs).
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  S_DATA;
    logic [5:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  sampled_bit;
    logic [5:0]            edge_count;
    logic                  dat_samp_en;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output S_DATA, Prescale, PAR_EN, PAR_TYP, sampled_bit,
        input  edge_count, dat_samp_en, P_DATA, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  S_DATA, Prescale, PAR_EN, PAR_TYP, sampled_bit,
        output edge_count, dat_samp_en, P_DATA, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start detection, per-bit edge counter, LSB-first
// deserialisation, optional parity and stop checks, one-cycle result pulses.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_rx_frame_ctrl_if.slave   rx_if
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_r;
    logic [5:0]            edge_count_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] shreg_r;
    logic [DATA_WIDTH-1:0] p_data_r;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic                  par_fail_r;
    logic                  stop_done_r;
    logic                  busy_r;
    logic                  data_valid_r;
    logic                  par_err_r;
    logic                  stp_err_r;
    logic                  prescale_ok_s;
    logic                  bit_end_s;

    // Expected parity bit for the received data under even (0) or odd (1) parity.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign prescale_ok_s = (rx_if.Prescale == 6'd8) || (rx_if.Prescale == 6'd16) ||
                           (rx_if.Prescale == 6'd32);
    assign bit_end_s     = (edge_count_r == (rx_if.Prescale - 6'd1));

    assign rx_if.edge_count  = edge_count_r;
    assign rx_if.dat_samp_en = busy_r;
    assign rx_if.busy        = busy_r;
    assign rx_if.P_DATA      = p_data_r;
    assign rx_if.data_valid  = data_valid_r;
    assign rx_if.par_err     = par_err_r;
    assign rx_if.stp_err     = stp_err_r;

    // Frame FSM, edge counter, deserialiser and result pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= IDLE;
            edge_count_r <= 6'd0;
            bit_cnt_r    <= '0;
            shreg_r      <= '0;
            p_data_r     <= '0;
            par_en_r     <= 1'b0;
            par_typ_r    <= 1'b0;
            par_fail_r   <= 1'b0;
            stop_done_r  <= 1'b0;
            busy_r       <= 1'b0;
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;
            stop_done_r  <= 1'b0;

            // The sampler still holds the stop-bit vote one edge after the frame ends.
            if (stop_done_r) begin
                stp_err_r <= ~rx_if.sampled_bit;
                par_err_r <= par_fail_r;
                if (rx_if.sampled_bit && !par_fail_r) begin
                    p_data_r     <= shreg_r;
                    data_valid_r <= 1'b1;
                end
            end

            if ((state_r == IDLE) || bit_end_s) begin
                edge_count_r <= 6'd0;
            end else begin
                edge_count_r <= edge_count_r + 6'd1;
            end

            case (state_r)
                IDLE: begin
                    if (!rx_if.S_DATA && prescale_ok_s) begin
                        state_r    <= START;
                        busy_r     <= 1'b1;
                        par_en_r   <= rx_if.PAR_EN;
                        par_typ_r  <= rx_if.PAR_TYP;
                        par_fail_r <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        if (!rx_if.sampled_bit) begin
                            state_r   <= DATA;
                            bit_cnt_r <= '0;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        shreg_r   <= {rx_if.sampled_bit, shreg_r[DATA_WIDTH-1:1]};
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        if (bit_cnt_r == CNT_W'(DATA_WIDTH - 1)) begin
                            state_r <= par_en_r ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        par_fail_r <= (rx_if.sampled_bit != parity_bit(shreg_r, par_typ_r));
                        state_r    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        stop_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
